// File: rtl/ring_step_ctrl.sv
// Control stage that feeds the rotating segment-pattern ring: button debounce,
// run/idle/load FSM and a power-of-two step prescaler producing advance/load strobes.
module ring_step_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_btn,
  input  logic       load_btn,
  input  logic [4:0] div_sel,
  output logic       advance,
  output logic       load,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       btn_raw;
  logic [1:0]       press;
  logic             run_ev;
  logic             load_ev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mask;
  logic             adv_due;
  logic             running_d;
  logic             load_d;
  logic             advance_d;

  assign btn_raw = {load_btn, run_btn};

  // Per button: two-flop synchronizer, then a level debouncer. The press event is
  // the cycle in which the debounced level flips 0->1, so it is one cycle wide.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             s1;
    logic             s2;
    logic             lvl;
    logic [DEB_W-1:0] dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        lvl  <= 1'b0;
        dcnt <= '0;
      end else begin
        s1 <= btn_raw[g];
        s2 <= s1;
        if (s2 == lvl) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          lvl  <= s2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DEB_W'(1);
        end
      end
    end

    assign press[g] = s2 & ~lvl & (dcnt == DEB_LAST);
  end

  assign run_ev  = press[0];
  assign load_ev = press[1];

  // Step mask saturates at the full counter width.
  always_comb begin
    mask = '0;
    if (32'(div_sel) >= CNT_W) begin
      mask = '1;
    end else begin
      mask = ~(ALL_ONES << div_sel);
    end
  end

  assign adv_due = ((cnt & mask) == mask);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: load beats run when both press in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_ev) begin
          state_d = ST_LOAD;
        end else if (run_ev) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_ev) begin
          state_d = ST_LOAD;
        end else if (run_ev) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode on the next state; advance needs RUN both now and next so a stop
  // or load never leaves a trailing strobe.
  always_comb begin
    running_d = 1'b0;
    load_d    = 1'b0;
    advance_d = 1'b0;
    running_d = (state_d == ST_RUN);
    load_d    = (state_d == ST_LOAD);
    advance_d = (state_q == ST_RUN) && (state_d == ST_RUN) && adv_due;
  end

  // Prescaler counts only while staying in RUN, so every RUN entry starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      load    <= 1'b0;
      advance <= 1'b0;
    end else begin
      running <= running_d;
      load    <= load_d;
      advance <= advance_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ring_step_ctrl.sv
// Directed bench for ring_step_ctrl with DEB_CYCLES=4, CNT_W=8; expected values
// are hand-derived cycle counts from the raw button edges.
module tb_ring_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_btn = 1'b0;
  logic       load_btn = 1'b0;
  logic [4:0] div_sel = 5'd0;
  logic       advance;
  logic       load;
  logic       running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int n_adv;
  int first;
  int last;
  int gap;
  int bad;
  int found;

  ring_step_ctrl #(
    .DEB_CYCLES(4),
    .CNT_W     (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_btn (run_btn),
    .load_btn(load_btn),
    .div_sel (div_sel),
    .advance (advance),
    .load    (load),
    .running (running),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({advance, load, running, state});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset and idle
    tick(3);
    check("reset_held", outs(), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("first_after_release", outs(), 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (outs() != 32'd0) bad++;
    end
    check("idle_100", 32'(bad), 32'd0);

    // 3-cycle glitch is rejected
    run_btn = 1'b1;
    tick(3);
    run_btn = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (state != 2'b00 || running) bad++;
    end
    check("glitch_3cyc", 32'(bad), 32'd0);

    // held press: running rises 6 cycles after the raw edge
    div_sel = 5'd3;
    run_btn = 1'b1;
    tick(5);
    check("run_before_6", 32'(running), 32'd0);
    tick(1);
    check("run_at_6", 32'(running), 32'd1);
    check("state_run", 32'(state), 32'd1);

    // div_sel=3: 10 pulses in 80 cycles, first at +8, spacing 8
    n_adv = 0; first = -1; last = -1; bad = 0;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      if (k == 14) run_btn = 1'b0;
      if (!running) bad++;
      if (advance) begin
        if (first < 0) first = k;
        else if (k - last != 8) bad++;
        last = k;
        n_adv++;
      end
    end
    check("adv_count_80", 32'(n_adv), 32'd10);
    check("adv_first_8", 32'(first), 32'd8);
    check("adv_spacing_8", 32'(bad), 32'd0);

    // div_sel=0: every cycle
    div_sel = 5'd0;
    n_adv = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (advance) n_adv++;
    end
    check("div0_every_cycle", 32'(n_adv), 32'd5);

    // switch to div_sel=4 mid-run
    div_sel = 5'd4;
    first = -1; gap = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (advance) begin
        if (first < 0) first = k;
        else if (gap == 0) gap = k - first;
      end
    end
    check("div4_first_within_16", 32'(first >= 1 && first <= 16), 32'd1);
    check("div4_period", 32'(gap), 32'd16);

    // div_sel=31 saturates at 256
    div_sel = 5'd31;
    first = -1; gap = 0;
    for (int k = 1; k <= 600; k++) begin
      tick(1);
      if (advance) begin
        if (first < 0) first = k;
        else if (gap == 0) gap = k - first;
      end
    end
    check("div31_period", 32'(gap), 32'd256);

    // stop press timed to land on a due advance
    div_sel = 5'd3;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (advance) begin
        found = 1;
        break;
      end
    end
    check("div3_resync", 32'(found), 32'd1);
    tick(2);
    run_btn = 1'b1;
    tick(5);
    check("stop_pending_running", 32'(running), 32'd1);
    tick(1);
    check("stop_outs", outs(), 32'd0);
    run_btn = 1'b0;
    n_adv = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (advance || running) n_adv++;
    end
    check("quiet_after_stop", 32'(n_adv), 32'd0);

    // prescaler restarts from 0 on re-entry
    run_btn = 1'b1;
    tick(6);
    check("rerun_running", 32'(running), 32'd1);
    n_adv = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (i == 3) run_btn = 1'b0;
      if (advance) n_adv++;
    end
    check("restart_no_early_adv", 32'(n_adv), 32'd0);
    tick(1);
    check("restart_first_adv_8", 32'(advance), 32'd1);

    // load press in RUN
    load_btn = 1'b1;
    tick(5);
    check("load_pre", 32'({load, state}), 32'd1);
    tick(1);
    check("load_pulse", outs(), 32'b01010);
    tick(1);
    check("load_to_idle", outs(), 32'd0);
    load_btn = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (advance || load || running) bad++;
    end
    check("after_load_quiet", 32'(bad), 32'd0);

    // simultaneous run and load: load wins
    run_btn = 1'b1;
    load_btn = 1'b1;
    tick(6);
    check("simul_load", outs(), 32'b01010);
    tick(1);
    check("simul_idle", outs(), 32'd0);
    run_btn = 1'b0;
    load_btn = 1'b0;
    tick(20);
    check("simul_stays_idle", outs(), 32'd0);

    // asynchronous reset in the middle of a run
    div_sel = 5'd2;
    run_btn = 1'b1;
    tick(6);
    check("run_div2", 32'(running), 32'd1);
    run_btn = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (advance) begin
        found = 1;
        break;
      end
    end
    check("div2_adv_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("post_reset_first", outs(), 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (outs() != 32'd0) bad++;
    end
    check("post_reset_idle_100", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
